// File: rtl/axi4l_led_slave.sv
// AXI4-Lite register slave driving an LED bank, with an optional blink phase
// that gates the LED pattern. Registers: CTRL, PATTERN, PERIOD, STATUS (RO).

module axi4l_led_slave #(
   parameter int          C_S_AXI_DATA_WIDTH = 32,
   parameter int          C_S_AXI_ADDR_WIDTH = 4,
   parameter int          NUM_LEDS           = 8,
   parameter logic [31:0] DEFAULT_PERIOD     = 32'd50000000
) (
   input  logic                            S_AXI_ACLK,
   input  logic                            S_AXI_ARESET,
   input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
   input  logic [2:0]                      S_AXI_AWPROT,
   input  logic                            S_AXI_AWVALID,
   output logic                            S_AXI_AWREADY,
   input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
   input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
   input  logic                            S_AXI_WVALID,
   output logic                            S_AXI_WREADY,
   output logic [1:0]                      S_AXI_BRESP,
   output logic                            S_AXI_BVALID,
   input  logic                            S_AXI_BREADY,
   input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
   input  logic [2:0]                      S_AXI_ARPROT,
   input  logic                            S_AXI_ARVALID,
   output logic                            S_AXI_ARREADY,
   output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
   output logic [1:0]                      S_AXI_RRESP,
   output logic                            S_AXI_RVALID,
   input  logic                            S_AXI_RREADY,
   output logic [NUM_LEDS-1:0]             led_o
);

   localparam int NUM_BYTES = C_S_AXI_DATA_WIDTH / 8;

   typedef enum logic [1:0] {
      REG_CTRL    = 2'd0,
      REG_PATTERN = 2'd1,
      REG_PERIOD  = 2'd2,
      REG_STATUS  = 2'd3
   } reg_e;

   logic [1:0]          rst_sync;
   logic                rst;
   logic                awready, bvalid, arready, rvalid;
   logic [1:0]          bresp;
   logic [31:0]         rdata;
   logic                ctrl_en, ctrl_blink;
   logic [NUM_LEDS-1:0] pattern;
   logic [31:0]         period, counter, eff_period;
   logic                phase;
   logic [NUM_LEDS-1:0] led;
   logic                wr_fire, rd_fire, period_wr;
   logic [1:0]          wr_sel, rd_sel;
   reg_e                wr_idx;
   logic [31:0]         reg_view [4];
   logic [31:0]         wr_merged;
   logic [63:0]         led_shifted;
   logic                unused;

   // Reset asserts immediately but releases two clock edges later, on an edge.
   always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
      if (S_AXI_ARESET) rst_sync <= 2'b11;
      else              rst_sync <= {rst_sync[0], 1'b0};
   end
   assign rst = rst_sync[1];

   assign wr_sel     = S_AXI_AWADDR[3:2];
   assign rd_sel     = S_AXI_ARADDR[3:2];
   assign wr_idx     = reg_e'(wr_sel);
   assign wr_fire    = awready & S_AXI_AWVALID & S_AXI_WVALID;
   assign rd_fire    = arready & S_AXI_ARVALID;
   assign period_wr  = wr_fire && (wr_idx == REG_PERIOD);
   assign eff_period = (period == 32'd0) ? 32'd1 : period;
   assign unused     = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

   // NOTE: every combinational output gets a default before any conditional
   // update, so no path leaves it unassigned and no latch is inferred.
   always_comb begin
      led_shifted = 64'(led) << 8;
      reg_view[0] = {30'd0, ctrl_blink, ctrl_en};
      reg_view[1] = 32'(pattern);
      reg_view[2] = period;
      reg_view[3] = led_shifted[31:0] | {31'd0, phase};
      wr_merged   = reg_view[wr_sel];
      for (int b = 0; b < NUM_BYTES; b++) begin
         if (S_AXI_WSTRB[b]) wr_merged[8*b +: 8] = S_AXI_WDATA[8*b +: 8];
      end
   end

   // NOTE: state is updated with non-blocking assignments only, so a read and
   // a write retiring on the same edge see the register's pre-write value.
   always_ff @(posedge S_AXI_ACLK or posedge rst) begin
      if (rst) begin
         awready    <= 1'b0;
         bvalid     <= 1'b0;
         bresp      <= 2'b00;
         ctrl_en    <= 1'b0;
         ctrl_blink <= 1'b0;
         pattern    <= '0;
         period     <= DEFAULT_PERIOD;
      end else begin
         awready <= S_AXI_AWVALID & S_AXI_WVALID & ~bvalid & ~awready;
         if (wr_fire) begin
            bvalid <= 1'b1;
            bresp  <= (wr_idx == REG_STATUS) ? 2'b10 : 2'b00;
            unique case (wr_idx)
               REG_CTRL: begin
                  ctrl_en    <= wr_merged[0];
                  ctrl_blink <= wr_merged[1];
               end
               REG_PATTERN: pattern <= wr_merged[NUM_LEDS-1:0];
               REG_PERIOD:  period  <= wr_merged;
               REG_STATUS:  ;
            endcase
         end else if (bvalid && S_AXI_BREADY) begin
            bvalid <= 1'b0;
         end
      end
   end

   always_ff @(posedge S_AXI_ACLK or posedge rst) begin
      if (rst) begin
         arready <= 1'b0;
         rvalid  <= 1'b0;
         rdata   <= 32'd0;
      end else begin
         arready <= S_AXI_ARVALID & ~rvalid & ~arready;
         if (rd_fire) begin
            rvalid <= 1'b1;
            rdata  <= reg_view[rd_sel];
         end else if (rvalid && S_AXI_RREADY) begin
            rvalid <= 1'b0;
         end
      end
   end

   // A PERIOD write restarts the count so a smaller period never has to wrap.
   always_ff @(posedge S_AXI_ACLK or posedge rst) begin
      if (rst) begin
         counter <= 32'd0;
         phase   <= 1'b1;
         led     <= '0;
      end else begin
         if (!(ctrl_en && ctrl_blink)) begin
            counter <= 32'd0;
            phase   <= 1'b1;
         end else if (period_wr) begin
            counter <= 32'd0;
         end else if (counter == eff_period - 32'd1) begin
            counter <= 32'd0;
            phase   <= ~phase;
         end else begin
            counter <= counter + 32'd1;
         end

         if (!ctrl_en)         led <= '0;
         else if (!ctrl_blink) led <= pattern;
         else                  led <= phase ? pattern : '0;
      end
   end

   assign S_AXI_AWREADY = awready;
   assign S_AXI_WREADY  = awready;
   assign S_AXI_BVALID  = bvalid;
   assign S_AXI_BRESP   = bresp;
   assign S_AXI_ARREADY = arready;
   assign S_AXI_RVALID  = rvalid;
   assign S_AXI_RDATA   = rdata;
   assign S_AXI_RRESP   = 2'b00;
   assign led_o         = led;

endmodule

// File: tb/tb_axi4l_led_slave.sv
// Self-checking bench for axi4l_led_slave: directed protocol steps plus random
// register traffic compared against a register-level reference model.

module tb_axi4l_led_slave;

   localparam int          NL         = 8;
   localparam logic [31:0] DEF_PERIOD = 32'd50000000;

   logic          clk = 1'b0;
   logic          rst;
   logic [3:0]    awaddr, araddr;
   logic          awvalid, wvalid, bready, arvalid, rready;
   logic [31:0]   wdata;
   logic [3:0]    wstrb;
   logic          awready, wready, bvalid, arready, rvalid;
   logic [1:0]    bresp, rresp;
   logic [31:0]   rdata;
   logic [NL-1:0] led;

   int n_checks = 0;
   int n_errors = 0;

   // Reference model: the 32-bit read view of CTRL, PATTERN and PERIOD.
   logic [31:0] m_reg [3];

   axi4l_led_slave #(
      .C_S_AXI_DATA_WIDTH (32),
      .C_S_AXI_ADDR_WIDTH (4),
      .NUM_LEDS           (NL),
      .DEFAULT_PERIOD     (DEF_PERIOD)
   ) dut (
      .S_AXI_ACLK    (clk),
      .S_AXI_ARESET  (rst),
      .S_AXI_AWADDR  (awaddr),
      .S_AXI_AWPROT  (3'b000),
      .S_AXI_AWVALID (awvalid),
      .S_AXI_AWREADY (awready),
      .S_AXI_WDATA   (wdata),
      .S_AXI_WSTRB   (wstrb),
      .S_AXI_WVALID  (wvalid),
      .S_AXI_WREADY  (wready),
      .S_AXI_BRESP   (bresp),
      .S_AXI_BVALID  (bvalid),
      .S_AXI_BREADY  (bready),
      .S_AXI_ARADDR  (araddr),
      .S_AXI_ARPROT  (3'b000),
      .S_AXI_ARVALID (arvalid),
      .S_AXI_ARREADY (arready),
      .S_AXI_RDATA   (rdata),
      .S_AXI_RRESP   (rresp),
      .S_AXI_RVALID  (rvalid),
      .S_AXI_RREADY  (rready),
      .led_o         (led)
   );

   initial forever #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] data,
                                         input logic [3:0] strb);
      logic [31:0] r;
      r = old;
      for (int b = 0; b < 4; b++) if (strb[b]) r[8*b +: 8] = data[8*b +: 8];
      return r;
   endfunction

   function automatic void model_write(input logic [3:0] addr, input logic [31:0] data,
                                       input logic [3:0] strb);
      case (addr[3:2])
         2'd0: m_reg[0] = merge(m_reg[0], data, strb) & 32'h3;
         2'd1: m_reg[1] = merge(m_reg[1], data, strb) & ((32'd1 << NL) - 32'd1);
         2'd2: m_reg[2] = merge(m_reg[2], data, strb);
         default: ;
      endcase
   endfunction

   function automatic void model_reset();
      m_reg[0] = 32'd0;
      m_reg[1] = 32'd0;
      m_reg[2] = DEF_PERIOD;
   endfunction

   // STATUS when not blinking: phase is 1 and the LEDs show PATTERN iff EN.
   function automatic logic [31:0] steady_status();
      logic [31:0] leds;
      leds = m_reg[0][0] ? m_reg[1] : 32'd0;
      return (leds << 8) | 32'd1;
   endfunction

   task automatic axi_write(input logic [3:0] addr, input logic [31:0] data,
                            input logic [3:0] strb, output logic [1:0] resp);
      int n;
      @(negedge clk);
      awaddr = addr; wdata = data; wstrb = strb; awvalid = 1'b1; wvalid = 1'b1;
      n = 0;
      do begin @(negedge clk); n++; end while (!awready && n < 50);
      if (!awready) check("aw_timeout", {31'd0, awready}, 32'd1);
      @(negedge clk);
      awvalid = 1'b0; wvalid = 1'b0;
      n = 0;
      while (!bvalid && n < 50) begin @(negedge clk); n++; end
      if (!bvalid) check("b_timeout", {31'd0, bvalid}, 32'd1);
      resp = bresp;
      bready = 1'b1;
      @(negedge clk);
      bready = 1'b0;
   endtask

   task automatic axi_read(input logic [3:0] addr, output logic [31:0] data,
                           output logic [1:0] resp);
      int n;
      @(negedge clk);
      araddr = addr; arvalid = 1'b1;
      n = 0;
      do begin @(negedge clk); n++; end while (!arready && n < 50);
      if (!arready) check("ar_timeout", {31'd0, arready}, 32'd1);
      @(negedge clk);
      arvalid = 1'b0;
      n = 0;
      while (!rvalid && n < 50) begin @(negedge clk); n++; end
      if (!rvalid) check("r_timeout", {31'd0, rvalid}, 32'd1);
      data = rdata; resp = rresp;
      rready = 1'b1;
      @(negedge clk);
      rready = 1'b0;
   endtask

   task automatic do_write(input logic [3:0] addr, input logic [31:0] data, input logic [3:0] strb);
      logic [1:0] resp;
      axi_write(addr, data, strb, resp);
      check($sformatf("bresp@%h", addr), {30'd0, resp}, (addr[3:2] == 2'd3) ? 32'd2 : 32'd0);
      model_write(addr, data, strb);
   endtask

   task automatic read_check(input string tag, input logic [3:0] addr, input logic [31:0] exp);
      logic [31:0] d;
      logic [1:0]  resp;
      axi_read(addr, d, resp);
      check(tag, d, exp);
      check({tag, "_rresp"}, {30'd0, resp}, 32'd0);
   endtask

   // Sample the LEDs for a window; every complete run must last exp_run cycles.
   task automatic check_blink(input string tag, input int exp_run, input logic [NL-1:0] pat);
      logic [NL-1:0] prev, cur;
      int run, toggles, bad;
      @(negedge clk);
      prev = led; run = 1; toggles = 0; bad = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         cur = led;
         if (cur !== '0 && cur !== pat) bad++;
         if (cur === prev) run++;
         else begin
            if (toggles > 0) check({tag, "_run"}, run, exp_run);
            toggles++;
            run  = 1;
            prev = cur;
         end
      end
      check({tag, "_values"}, bad, 0);
      check({tag, "_toggled"}, {31'd0, toggles >= 4}, 32'd1);
   endtask

   initial begin
      logic [31:0] d;
      logic [1:0]  resp;
      int n;

      rst = 1'b1;
      awaddr = '0; araddr = '0; wdata = '0; wstrb = '0;
      awvalid = 1'b0; wvalid = 1'b0; bready = 1'b0; arvalid = 1'b0; rready = 1'b0;
      model_reset();
      repeat (3) @(negedge clk);
      check("rst_awready", {31'd0, awready}, 32'd0);
      check("rst_bvalid",  {31'd0, bvalid},  32'd0);
      check("rst_arready", {31'd0, arready}, 32'd0);
      check("rst_rvalid",  {31'd0, rvalid},  32'd0);
      check("rst_rdata",   rdata, 32'd0);
      check("rst_led",     32'(led), 32'd0);
      rst = 1'b0;
      repeat (4) @(negedge clk);

      read_check("rst_ctrl",    4'h0, 32'd0);
      read_check("rst_pattern", 4'h4, 32'd0);
      read_check("rst_period",  4'h8, DEF_PERIOD);
      read_check("rst_status",  4'hC, 32'd1);
      check("rst_led_after", 32'(led), 32'd0);

      // W leads AW by three cycles; B held off five cycles with a second write queued.
      @(negedge clk);
      awaddr = 4'h8; wdata = 32'h100; wstrb = 4'hF; wvalid = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("early_w_awready", {31'd0, awready}, 32'd0);
         check("early_w_wready",  {31'd0, wready},  32'd0);
      end
      awvalid = 1'b1;
      n = 0;
      do begin @(negedge clk); n++; end while (!awready && n < 50);
      check("aw_accept", {31'd0, awready}, 32'd1);
      check("w_accept_same_cycle", {31'd0, wready}, 32'd1);
      model_write(4'h8, 32'h100, 4'hF);
      @(negedge clk);
      check("aw_pulse_one_cycle", {31'd0, awready}, 32'd0);
      awaddr = 4'h8; wdata = 32'h200;
      for (int i = 0; i < 5; i++) begin
         check("b_held",            {31'd0, bvalid},  32'd1);
         check("b_held_resp",       {30'd0, bresp},   32'd0);
         check("queued_not_accept", {31'd0, awready}, 32'd0);
         @(negedge clk);
      end
      bready = 1'b1;
      @(negedge clk);
      bready = 1'b0;
      check("b_dropped", {31'd0, bvalid}, 32'd0);
      check("queued_gap", {31'd0, awready}, 32'd0);
      n = 0;
      while (!awready && n < 50) begin @(negedge clk); n++; end
      check("queued_accept", {31'd0, awready}, 32'd1);
      @(negedge clk);
      awvalid = 1'b0; wvalid = 1'b0;
      check("queued_bvalid", {31'd0, bvalid}, 32'd1);
      bready = 1'b1;
      @(negedge clk);
      bready = 1'b0;
      model_write(4'h8, 32'h200, 4'hF);
      read_check("queued_period", 4'h8, m_reg[2]);

      // Steady LED drive.
      do_write(4'h4, 32'hA5, 4'hF);
      do_write(4'h0, 32'h1, 4'hF);
      check("led_enabled", 32'(led), 32'hA5);
      read_check("status_enabled", 4'hC, 32'h0000A501);

      // Blink at PERIOD 4 then PERIOD 0 (treated as 1).
      do_write(4'h8, 32'd4, 4'hF);
      do_write(4'h0, 32'h3, 4'hF);
      check_blink("blink4", 4, 8'hA5);
      do_write(4'h8, 32'd0, 4'hF);
      check_blink("blink0", 1, 8'hA5);

      // STATUS is read-only; byte strobes keep unstrobed bytes.
      do_write(4'h0, 32'h1, 4'hF);
      read_check("status_before_wr", 4'hC, steady_status());
      do_write(4'hC, 32'hDEADBEEF, 4'hF);
      read_check("status_after_wr", 4'hC, 32'h0000A501);
      do_write(4'h4, 32'hFFFFFF3C, 4'b0001);
      read_check("pattern_strobe", 4'h4, 32'h3C);

      // Read and write of PATTERN retiring on the same edge.
      @(negedge clk);
      awaddr = 4'h4; wdata = 32'h11; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
      araddr = 4'h4; arvalid = 1'b1;
      n = 0;
      do begin @(negedge clk); n++; end while (!awready && !arready && n < 50);
      check("same_awready", {31'd0, awready}, 32'd1);
      check("same_arready", {31'd0, arready}, 32'd1);
      @(negedge clk);
      awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
      check("same_rvalid", {31'd0, rvalid}, 32'd1);
      check("same_rdata_old", rdata, 32'h3C);
      bready = 1'b1; rready = 1'b1;
      @(negedge clk);
      bready = 1'b0; rready = 1'b0;
      model_write(4'h4, 32'h11, 4'hF);
      read_check("same_rdata_new", 4'h4, 32'h11);

      // Random register traffic against the model.
      for (int i = 0; i < 30; i++) begin
         logic [3:0] wa, ra;
         wa = {2'($urandom_range(0, 3)), 2'b00};
         ra = {2'($urandom_range(0, 3)), 2'b00};
         do_write(wa, $urandom, 4'($urandom_range(0, 15)));
         if (ra[3:2] != 2'd3) read_check("rand_rd", ra, m_reg[ra[3:2]]);
         else if (m_reg[0][1:0] != 2'b11) read_check("rand_status", ra, steady_status());
         else begin
            axi_read(ra, d, resp);
            check("rand_status_rresp", {30'd0, resp}, 32'd0);
         end
      end

      // Reset while RVALID is held.
      @(negedge clk);
      araddr = 4'h0; arvalid = 1'b1;
      n = 0;
      do begin @(negedge clk); n++; end while (!arready && n < 50);
      @(negedge clk);
      arvalid = 1'b0;
      @(negedge clk);
      check("rvalid_held", {31'd0, rvalid}, 32'd1);
      #2 rst = 1'b1;
      #1;
      check("rst_async_rvalid", {31'd0, rvalid}, 32'd0);
      check("rst_async_rdata",  rdata, 32'd0);
      check("rst_async_led",    32'(led), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      repeat (4) @(negedge clk);
      model_reset();
      read_check("rerst_ctrl",    4'h0, m_reg[0]);
      read_check("rerst_pattern", 4'h4, m_reg[1]);
      read_check("rerst_period",  4'h8, m_reg[2]);
      read_check("rerst_status",  4'hC, steady_status());

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
